// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display path: active-low
// glyphs {g,f,e,d,c,b,a}, the BCD conversion states and small helpers.
package seg7_pkg;

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_e;

    // BCD nibble to glyph; codes above 9 never come out of the converter, show blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return SEG_DIGIT[nibble];
        end
        return SEG_BLANK;
    endfunction

    // Nibbles needed to hold any value_w-bit binary number: ceil((w+3)/3)+1.
    function automatic int unsigned bcd_nibbles(input int unsigned value_w);
        return (value_w + 5) / 3 + 1;
    endfunction

endpackage

// File: rtl/seg7_mux_driver_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter. One shift per clock; a load
// that arrives while busy is parked in a one-deep pending slot (newest wins) and
// started straight from the commit cycle so busy never drops in between.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int unsigned VALUE_W     = 14,
    parameter int unsigned NUM_NIBBLES = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [VALUE_W-1:0]       value_i,
    input  logic                     load_i,
    output logic                     busy_o,
    output logic                     commit_o,
    output logic [NUM_NIBBLES*4-1:0] bcd_o
);

    localparam int unsigned BCD_W = NUM_NIBBLES * 4;
    localparam int unsigned WORK_W = BCD_W + VALUE_W;
    localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(VALUE_W - 1);

    conv_state_e        state_q;
    logic [WORK_W-1:0]  work_q;
    logic [WORK_W-1:0]  work_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic               pending_q;
    logic [VALUE_W-1:0] pending_val_q;
    logic               busy_q;
    logic               commit_q;
    logic [BCD_W-1:0]   bcd_q;

    // Add 3 to every BCD nibble >= 5 so the following doubling carries correctly.
    always_comb begin
        work_adj = work_q;
        for (int n = 0; n < int'(NUM_NIBBLES); n++) begin
            if (work_q[VALUE_W + 4*n +: 4] >= 4'd5) begin
                work_adj[VALUE_W + 4*n +: 4] = work_q[VALUE_W + 4*n +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM with registered busy, commit strobe and result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            work_q        <= '0;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            pending_val_q <= '0;
            busy_q        <= 1'b0;
            commit_q      <= 1'b0;
            bcd_q         <= '0;
        end else begin
            commit_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load_i) begin
                        work_q  <= {{BCD_W{1'b0}}, value_i};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (load_i) begin
                        pending_q     <= 1'b1;
                        pending_val_q <= value_i;
                    end
                    work_q <= {work_adj[WORK_W-2:0], 1'b0};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_SHIFT) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    commit_q <= 1'b1;
                    bcd_q    <= work_q[WORK_W-1 -: BCD_W];
                    cnt_q    <= '0;
                    // A load landing in this cycle is newer than anything pending.
                    if (load_i || pending_q) begin
                        work_q    <= {{BCD_W{1'b0}}, (load_i ? value_i : pending_val_q)};
                        pending_q <= 1'b0;
                        state_q   <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign commit_o = commit_q;
    assign bcd_o    = bcd_q;

endmodule

// File: rtl/seg7_mux_driver.sv
// N-digit multiplexed 7-segment driver: sequential BCD conversion into a display
// register, anode scanning, "Err"/overflow dashes, leading-zero blanking and dp.
// Optional macro SEG7_GHOST_GUARD_EN blanks all anodes for the first GUARD_CYCLES
// counts of every slot to hide ghosting on slow anode drivers.
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned VALUE_W      = 14,
    parameter int unsigned REFRESH_DIV  = 65536,
    parameter int unsigned GUARD_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [VALUE_W-1:0]            value,
    input  logic                          load,
    input  logic                          show_error,
    input  logic                          blank_lz,
    input  logic                          dp_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] dp_pos,
    output logic                          busy,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an
);

    localparam int unsigned NUM_NIBBLES = bcd_nibbles(VALUE_W);
    localparam int unsigned SEL_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
`ifdef SEG7_GHOST_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic [NUM_NIBBLES*4-1:0] bcd;
    logic                     conv_commit;
    logic [NUM_DIGITS*4-1:0]  bcd_lo;
    logic                     bcd_hi_nz;
    logic [NUM_DIGITS*4-1:0]  disp_q;
    logic                     ovf_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [SEL_W-1:0]         digit_sel_q;
    logic [6:0]               seg_d, seg_q;
    logic                     dp_d, dp_q;
    logic [NUM_DIGITS-1:0]    an_d, an_q;
    logic [3:0]               sel_nib;
    logic                     upper_zero;
    logic                     lz_blank;

    bin2bcd_seq #(
        .VALUE_W     (VALUE_W),
        .NUM_NIBBLES (NUM_NIBBLES)
    ) u_bin2bcd (
        .clk      (clk),
        .reset    (reset),
        .value_i  (value),
        .load_i   (load),
        .busy_o   (busy),
        .commit_o (conv_commit),
        .bcd_o    (bcd)
    );

    // Split the result into displayable digits and an "anything above" overflow flag.
    always_comb begin
        bcd_lo    = '0;
        bcd_hi_nz = 1'b0;
        for (int n = 0; n < int'(NUM_NIBBLES); n++) begin
            if (n < int'(NUM_DIGITS)) begin
                bcd_lo[4*n +: 4] = bcd[4*n +: 4];
            end else begin
                bcd_hi_nz = bcd_hi_nz | (|bcd[4*n +: 4]);
            end
        end
    end

    // Display register only ever takes a completed conversion; overflow keeps old digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (conv_commit) begin
            if (bcd_hi_nz) begin
                ovf_q <= 1'b1;
            end else begin
                disp_q <= bcd_lo;
                ovf_q  <= 1'b0;
            end
        end
    end

    // Refresh counter and digit scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            digit_sel_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            digit_sel_q <= (digit_sel_q == SEL_LAST) ? '0 : digit_sel_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Glyph, dp and anode for the digit currently selected.
    always_comb begin
        sel_nib    = disp_q[{digit_sel_q, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (SEL_W'(i) >= digit_sel_q && disp_q[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        lz_blank = blank_lz && (digit_sel_q != '0) && upper_zero
                   && !(dp_en && (digit_sel_q <= dp_pos));

        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (show_error) begin
            if (digit_sel_q == SEL_W'(2)) begin
                seg_d = SEG_E;
            end else if (digit_sel_q < SEL_W'(2)) begin
                seg_d = SEG_R;
            end
        end else if (ovf_q) begin
            seg_d = SEG_DASH;
        end else begin
            seg_d = lz_blank ? SEG_BLANK : bcd_to_seg(sel_nib);
            dp_d  = !(dp_en && (digit_sel_q == dp_pos));
        end

        an_d = ~(NUM_DIGITS'(1) << digit_sel_q);
        if (GUARD_EN && (cnt_q < GUARD_END)) begin
            an_d = '1;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench for seg7_mux_driver (4 digits, 14-bit value, 4 clocks/slot).
module tb_seg7_mux_driver;

    localparam int NUM_DIGITS   = 4;
    localparam int VALUE_W      = 14;
    localparam int REFRESH_DIV  = 4;
    localparam int GUARD_CYCLES = 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [VALUE_W-1:0] value;
    logic               load;
    logic               show_error;
    logic               blank_lz;
    logic               dp_en;
    logic [1:0]         dp_pos;
    logic               busy;
    logic [6:0]         seg;
    logic               dp;
    logic [3:0]         an;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_val;
    bit m_ovf;
    bit m_err;
    bit m_blz;
    bit m_dpen;
    int m_dppos;

    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg7_mux_driver #(
        .NUM_DIGITS   (NUM_DIGITS),
        .VALUE_W      (VALUE_W),
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .show_error (show_error),
        .blank_lz   (blank_lz),
        .dp_en      (dp_en),
        .dp_pos     (dp_pos),
        .busy       (busy),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int i);
        int pw;
        pw = 10 ** i;
        if (m_err) return (i == 2) ? 7'h06 : ((i < 2) ? 7'h2F : 7'h7F);
        if (m_ovf) return 7'h3F;
        if (m_blz && i > 0 && m_val < pw && !(m_dpen && i <= m_dppos)) return 7'h7F;
        return glyph[(m_val / pw) % 10];
    endfunction

    function automatic logic ref_dp(input int i);
        return !(!m_err && !m_ovf && m_dpen && i == m_dppos);
    endfunction

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    task automatic apply_flags();
        @(negedge clk);
        show_error = m_err;
        blank_lz   = m_blz;
        dp_en      = m_dpen;
        dp_pos     = 2'(m_dppos);
    endtask

    // Returns at the negedge after the load edge.
    task automatic do_load(input int v);
        @(negedge clk);
        value = VALUE_W'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_idle_timeout"}, 32'(busy), 0);
    endtask

    task automatic model_load(input int v);
        if (v > 9999) m_ovf = 1'b1;
        else begin
            m_val = v;
            m_ovf = 1'b0;
        end
    endtask

    // One full scan: every lit digit must match the model, every digit must appear.
    task automatic scan(input string tag);
        int seen;
        int dark;
        int zeros;
        int k;
        seen = 0;
        dark = 0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < NUM_DIGITS * REFRESH_DIV; c++) begin
            @(negedge clk);
            if (an == 4'hF) begin
                dark++;
            end else begin
                zeros = 0;
                k = 0;
                for (int b = 0; b < NUM_DIGITS; b++) begin
                    if (!an[b]) begin
                        zeros++;
                        k = b;
                    end
                end
                chk({tag, "_an_onehot"}, 32'(zeros), 1);
                chk({tag, "_seg"}, {k[7:0], 17'd0, seg}, {k[7:0], 17'd0, ref_seg(k)});
                chk({tag, "_dp"}, {k[7:0], 23'd0, dp}, {k[7:0], 23'd0, ref_dp(k)});
                seen |= (1 << k);
            end
        end
        chk({tag, "_all_digits"}, 32'(seen), 32'hF);
`ifdef SEG7_GHOST_GUARD_EN
        chk({tag, "_guard_cycles"}, 32'(dark), 32'(NUM_DIGITS * GUARD_CYCLES));
`else
        chk({tag, "_guard_cycles"}, 32'(dark), 0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        value = '0;
        load = 1'b0;
        show_error = 1'b0;
        blank_lz = 1'b1;
        dp_en = 1'b0;
        dp_pos = 2'd0;
        m_val = 0; m_ovf = 0; m_err = 0; m_blz = 1; m_dpen = 0; m_dppos = 0;

        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_dp", 32'(dp), 1);
        chk("rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        scan("after_reset");

        // 1234: busy for 15 cycles, display register changes 16 cycles after load.
        do_load(1234);
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("busy_1234_k%0d", k), 32'(busy), 32'(k <= 14));
            if (k == 15) chk("disp_before_1234", 32'(dut.disp_q), 32'(ref_bcd(0)));
            if (k == 16) chk("disp_after_1234", 32'(dut.disp_q), 32'(ref_bcd(1234)));
        end
        model_load(1234);
        scan("show_1234");

        // 42, then 777 and 905 while busy: 905 overrides 777, busy never drops.
        do_load(42);
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 2) begin value = 14'd777; load = 1'b1; end
            if (k == 3) load = 1'b0;
            if (k == 5) begin value = 14'd905; load = 1'b1; end
            if (k == 6) load = 1'b0;
            chk($sformatf("busy_chain_k%0d", k), 32'(busy), 32'(k <= 29));
            if (k == 16) chk("disp_chain_42", 32'(dut.disp_q), 32'(ref_bcd(42)));
            if (k == 30) chk("disp_chain_hold", 32'(dut.disp_q), 32'(ref_bcd(42)));
            if (k == 31) chk("disp_chain_905", 32'(dut.disp_q), 32'(ref_bcd(905)));
        end
        model_load(905);
        scan("show_905");

        // Overflow dashes, then "0.07".
        do_load(12000);
        wait_idle("ovf");
        model_load(12000);
        scan("overflow");
        m_dpen = 1; m_dppos = 2;
        apply_flags();
        do_load(7);
        wait_idle("dp007");
        model_load(7);
        scan("show_0p07");
        m_dpen = 0; m_dppos = 0;
        apply_flags();

        // Err overlay leaves the display register alone.
        do_load(1234);
        wait_idle("err");
        model_load(1234);
        m_err = 1;
        apply_flags();
        scan("show_err");
        m_err = 0;
        apply_flags();
        scan("err_released");

        // Reset during SHIFT aborts everything.
        do_load(5555);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        @(negedge clk);
        reset = 1'b0;
        m_val = 0; m_ovf = 0;
        repeat (20) @(negedge clk);
        chk("midrst_busy_after", 32'(busy), 0);
        scan("midrst_zero");

        // Randomized values and display flags.
        for (int it = 0; it < 12; it++) begin
            int v;
            v = (it % 4 == 3) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
            m_blz = 1'($urandom);
            m_dpen = 1'($urandom);
            m_dppos = int'($urandom_range(0, 3));
            m_err = ($urandom_range(0, 5) == 0);
            apply_flags();
            do_load(v);
            wait_idle($sformatf("rand%0d", it));
            model_load(v);
            scan($sformatf("rand%0d_v%0d", it, v));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop if something wedges.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
